// File: rtl/log2_frac_seq_pkg.sv
// Shared types and constant helpers for the fractional log2 unit.
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        FRAC = 2'd2,
        DONE = 2'd3
    } log2State_t;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/log2_frac_seq_if.sv
// Operand/result handshake bundle for log2_frac_seq.
interface log2_frac_seq_if #(
    parameter int BIT_IN = 12,
    parameter int OUT_W  = 8
);
    logic              In_Valid;
    logic              In_Ready;
    logic [BIT_IN-1:0] DatIn_A;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [OUT_W-1:0]  DatOut;
    logic              Out_Err;

    modport master (
        output In_Valid, DatIn_A, Out_Ready,
        input  In_Ready, Out_Valid, DatOut, Out_Err
    );

    modport slave (
        input  In_Valid, DatIn_A, Out_Ready,
        output In_Ready, Out_Valid, DatOut, Out_Err
    );
endinterface

// File: rtl/log2_frac_seq_lead_one_enc.sv
// Leading-one priority encoder and normaliser: x -> (p, x << (BIT_IN-1-p), zero).
module lead_one_enc
    import log2_pkg::*;
#(
    parameter int BIT_IN = 12,
    parameter int INT_W  = clog2(BIT_IN)
) (
    input  logic [BIT_IN-1:0] operand,
    output logic [INT_W-1:0]  leadPos,
    output logic [BIT_IN-1:0] normMant,
    output logic              isZero
);

    always_comb begin
        leadPos = '0;
        isZero  = 1'b1;
        for (int i = 0; i < BIT_IN; i++) begin
            if (operand[i]) begin
                leadPos = INT_W'(i);
                isZero  = 1'b0;
            end
        end
        normMant = operand << (INT_W'(BIT_IN - 1) - leadPos);
    end

endmodule

// File: rtl/log2_frac_seq.sv
// Sequential log2: integer part from the leading one, fraction by repeated squaring.
// Define LOG2_ROUND_EN for a guard iteration with round-half-up and saturation.
module log2_frac_seq
    import log2_pkg::*;
#(
    parameter int BIT_IN    = 12,
    parameter int FRAC_BITS = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    log2_frac_seq_if.slave bus
);

    localparam int INT_W = clog2(BIT_IN);
    localparam int OUT_W = INT_W + FRAC_BITS;
`ifdef LOG2_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int ITER  = FRAC_BITS + RND;
    localparam int ACC_W = (ITER > 0) ? ITER : 1;
    localparam int CNT_W = clog2(ITER + 2);

    log2State_t        state;
    logic              inReady;
    logic              outValid;
    logic [OUT_W-1:0]  datOut;
    logic              outErr;

    logic [BIT_IN-1:0] operand;
    logic [INT_W-1:0]  intPart;
    logic [BIT_IN-1:0] mant;
    logic [ACC_W-1:0]  fracAcc;
    logic [CNT_W-1:0]  iterCnt;
    logic              zeroFlag;

    logic [INT_W-1:0]    encPos;
    logic [BIT_IN-1:0]   encMant;
    logic                encZero;
    logic [2*BIT_IN-1:0] sq;
    logic                sqMsb;
    logic [BIT_IN-1:0]   mantNext;

    function automatic logic [OUT_W-1:0] finalResult(
        input logic [INT_W-1:0] ip,
        input logic [ACC_W-1:0] acc
    );
`ifdef LOG2_ROUND_EN
        logic [OUT_W:0] sum;
        // acc[0] is the guard bit; a carry out of the integer part saturates.
        sum = (OUT_W+1)'({ip, acc} >> 1) + (OUT_W+1)'(acc[0]);
        return sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
        return OUT_W'({ip, acc} >> (ACC_W - FRAC_BITS));
`endif
    endfunction

    lead_one_enc #(
        .BIT_IN (BIT_IN),
        .INT_W  (INT_W)
    ) u_enc (
        .operand  (operand),
        .leadPos  (encPos),
        .normMant (encMant),
        .isZero   (encZero)
    );

    // m in 1.(BIT_IN-1); m*m in 2.(2*BIT_IN-2), renormalised by truncation.
    assign sq       = (2*BIT_IN)'(mant) * (2*BIT_IN)'(mant);
    assign sqMsb    = sq[2*BIT_IN-1];
    assign mantNext = sqMsb ? BIT_IN'(sq >> BIT_IN) : BIT_IN'(sq >> (BIT_IN - 1));

    assign bus.In_Ready  = inReady;
    assign bus.Out_Valid = outValid;
    assign bus.DatOut    = datOut;
    assign bus.Out_Err   = outErr;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= IDLE;
            inReady  <= 1'b0;
            outValid <= 1'b0;
            datOut   <= '0;
            outErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inReady && bus.In_Valid) begin
                        inReady <= 1'b0;
                        state   <= NORM;
                    end else begin
                        inReady <= 1'b1;
                    end
                end
                NORM: begin
                    if (encZero || ITER == 0) begin
                        state <= DONE;
                    end else begin
                        state <= FRAC;
                    end
                end
                FRAC: begin
                    if (iterCnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle finalises the result; later cycles wait for the consumer.
                    if (!outValid) begin
                        outValid <= 1'b1;
                        outErr   <= zeroFlag;
                        datOut   <= zeroFlag ? '0 : finalResult(intPart, fracAcc);
                    end else if (bus.Out_Ready) begin
                        outValid <= 1'b0;
                        outErr   <= 1'b0;
                        inReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        case (state)
            IDLE: begin
                if (inReady && bus.In_Valid) begin
                    operand <= bus.DatIn_A;
                end
            end
            NORM: begin
                intPart  <= encPos;
                mant     <= encMant;
                zeroFlag <= encZero;
                fracAcc  <= '0;
                iterCnt  <= CNT_W'(ITER);
            end
            FRAC: begin
                mant    <= mantNext;
                fracAcc <= ACC_W'({fracAcc, sqMsb});
                iterCnt <= iterCnt - CNT_W'(1);
            end
            default: ;
        endcase
    end

endmodule
